membus_arbiter: RTL and testbench

Two-master to one-slave MemBus arbiter between the core's instruction bus (ibus) and data bus (dbus) and a single shared memory port. Forwards one command per handshake with round-robin priority and records the source of every read in an in-order tag FIFO. Routes each read response back to the master that issued it. Writes produce no response and use no FIFO entry.

---
 rtl/membus_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_membus_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/membus_arbiter.sv
// membus_arbiter
//
// Two-master (ibus, dbus) to one-slave MemBus arbiter. Commands are granted
// round-robin and forwarded combinationally. Every forwarded read pushes its
// source tag into an in-order tag FIFO, and the FIFO head steers each memory
// response back to the master that issued the read. Writes return nothing
// and take no FIFO entry.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   ibus_cmd_*            ibus read command (valid/ready/address)
//   ibus_rsp_*            ibus read response (valid/ready/rdata)
//   dbus_cmd_*            dbus command (valid/ready/address/write/wdata/wmask)
//   dbus_rsp_*            dbus read response (valid/ready/rdata)
//   mem_cmd_*             shared memory command
//   mem_rsp_*             shared memory response
//   protocol_error        sticky: a response arrived with no read outstanding
//
// Parameter
//   DEPTH                 maximum outstanding reads, power of two, >= 2
module membus_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        ibus_cmd_valid,
  output logic        ibus_cmd_ready,
  input  logic [31:0] ibus_cmd_payload_address,
  output logic        ibus_rsp_valid,
  input  logic        ibus_rsp_ready,
  output logic [31:0] ibus_rsp_payload_rdata,

  input  logic        dbus_cmd_valid,
  output logic        dbus_cmd_ready,
  input  logic [31:0] dbus_cmd_payload_address,
  input  logic        dbus_cmd_payload_write,
  input  logic [31:0] dbus_cmd_payload_wdata,
  input  logic [3:0]  dbus_cmd_payload_wmask,
  output logic        dbus_rsp_valid,
  input  logic        dbus_rsp_ready,
  output logic [31:0] dbus_rsp_payload_rdata,

  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic [31:0] mem_cmd_payload_address,
  output logic        mem_cmd_payload_write,
  output logic [31:0] mem_cmd_payload_wdata,
  output logic [3:0]  mem_cmd_payload_wmask,
  input  logic        mem_rsp_valid,
  output logic        mem_rsp_ready,
  input  logic [31:0] mem_rsp_payload_rdata,

  output logic        protocol_error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [DEPTH-1:0] r_tags;     // 0 = ibus, 1 = dbus
  logic          r_last_src;    // 0 = ibus, 1 = dbus
  logic          r_perr;

  logic w_room;
  logic w_i_elig;
  logic w_d_elig;
  logic w_gnt_any;
  logic w_gnt_d;
  logic w_cmd_hs;
  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_head;
  logic w_spurious;

  // Room is judged on the registered count, so a pop in the same cycle does
  // not free a slot until the next cycle.
  assign w_room   = (r_count < FULL_CNT);
  assign w_i_elig = ibus_cmd_valid & w_room;
  assign w_d_elig = dbus_cmd_valid & (dbus_cmd_payload_write | w_room);

  // Grant selection
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_d   = 1'b0;
    case (r_state)
      ARB: begin
        w_gnt_any = w_i_elig | w_d_elig;
        if (w_i_elig && w_d_elig) begin
          // Tie: serve whoever was not served last.
          w_gnt_d = ~r_last_src;
        end else begin
          w_gnt_d = w_d_elig;
        end
      end
      HOLD_I: begin
        w_gnt_any = 1'b1;
        w_gnt_d   = 1'b0;
      end
      HOLD_D: begin
        w_gnt_any = 1'b1;
        w_gnt_d   = 1'b1;
      end
      default: begin
        w_gnt_any = 1'b0;
        w_gnt_d   = 1'b0;
      end
    endcase
  end

  // Command forwarding
  always_comb begin
    mem_cmd_valid           = 1'b0;
    mem_cmd_payload_address = ibus_cmd_payload_address;
    mem_cmd_payload_write   = 1'b0;
    mem_cmd_payload_wdata   = dbus_cmd_payload_wdata;
    mem_cmd_payload_wmask   = 4'h0;
    ibus_cmd_ready          = 1'b0;
    dbus_cmd_ready          = 1'b0;
    if (w_gnt_d) begin
      mem_cmd_valid           = w_gnt_any & dbus_cmd_valid;
      mem_cmd_payload_address = dbus_cmd_payload_address;
      mem_cmd_payload_write   = dbus_cmd_payload_write;
      mem_cmd_payload_wmask   = dbus_cmd_payload_wmask;
      dbus_cmd_ready          = w_gnt_any & mem_cmd_ready;
    end else begin
      mem_cmd_valid           = w_gnt_any & ibus_cmd_valid;
      ibus_cmd_ready          = w_gnt_any & mem_cmd_ready;
    end
  end

  assign w_cmd_hs = mem_cmd_valid & mem_cmd_ready;
  assign w_push   = w_cmd_hs & ~mem_cmd_payload_write;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB: begin
        if (w_gnt_any && !mem_cmd_ready) begin
          w_state_nxt = w_gnt_d ? HOLD_D : HOLD_I;
        end
      end
      HOLD_I, HOLD_D: begin
        if (w_cmd_hs) begin
          w_state_nxt = ARB;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  // Response routing: the FIFO head owns the response channel.
  assign w_empty    = (r_count == '0);
  assign w_head     = r_tags[r_rptr];
  assign w_spurious = w_empty & mem_rsp_valid;

  always_comb begin
    ibus_rsp_valid = 1'b0;
    dbus_rsp_valid = 1'b0;
    mem_rsp_ready  = 1'b0;
    if (w_empty) begin
      // Nobody is waiting: swallow whatever shows up.
      mem_rsp_ready = mem_rsp_valid;
    end else if (w_head) begin
      dbus_rsp_valid = mem_rsp_valid;
      mem_rsp_ready  = dbus_rsp_ready;
    end else begin
      ibus_rsp_valid = mem_rsp_valid;
      mem_rsp_ready  = ibus_rsp_ready;
    end
  end

  assign ibus_rsp_payload_rdata = mem_rsp_payload_rdata;
  assign dbus_rsp_payload_rdata = mem_rsp_payload_rdata;
  assign w_pop          = ~w_empty & mem_rsp_valid & mem_rsp_ready;
  assign protocol_error = r_perr;

  // Control state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ARB;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_last_src <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_hs) begin
        r_last_src <= w_gnt_d;
      end
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_spurious) begin
        r_perr <= 1'b1;
      end
    end
  end

  // Tag storage is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tags[r_wptr] <= w_gnt_d;
    end
  end

endmodule

// File: tb/tb_membus_arbiter.sv
// tb_membus_arbiter
//
// Directed scenarios followed by randomized traffic. A queue-based reference
// model (outstanding read tags, last-served master, locked grant, sticky
// error flag) predicts every output each cycle.
module tb_membus_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ibus_cmd_valid = 1'b0;
  logic        ibus_cmd_ready;
  logic [31:0] ibus_cmd_payload_address = '0;
  logic        ibus_rsp_valid;
  logic        ibus_rsp_ready = 1'b0;
  logic [31:0] ibus_rsp_payload_rdata;
  logic        dbus_cmd_valid = 1'b0;
  logic        dbus_cmd_ready;
  logic [31:0] dbus_cmd_payload_address = '0;
  logic        dbus_cmd_payload_write = 1'b0;
  logic [31:0] dbus_cmd_payload_wdata = '0;
  logic [3:0]  dbus_cmd_payload_wmask = '0;
  logic        dbus_rsp_valid;
  logic        dbus_rsp_ready = 1'b0;
  logic [31:0] dbus_rsp_payload_rdata;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready = 1'b0;
  logic [31:0] mem_cmd_payload_address;
  logic        mem_cmd_payload_write;
  logic [31:0] mem_cmd_payload_wdata;
  logic [3:0]  mem_cmd_payload_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic        mem_rsp_ready;
  logic [31:0] mem_rsp_payload_rdata = '0;
  logic        protocol_error;

  membus_arbiter #(.DEPTH(DEPTH)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .ibus_cmd_valid           (ibus_cmd_valid),
    .ibus_cmd_ready           (ibus_cmd_ready),
    .ibus_cmd_payload_address (ibus_cmd_payload_address),
    .ibus_rsp_valid           (ibus_rsp_valid),
    .ibus_rsp_ready           (ibus_rsp_ready),
    .ibus_rsp_payload_rdata   (ibus_rsp_payload_rdata),
    .dbus_cmd_valid           (dbus_cmd_valid),
    .dbus_cmd_ready           (dbus_cmd_ready),
    .dbus_cmd_payload_address (dbus_cmd_payload_address),
    .dbus_cmd_payload_write   (dbus_cmd_payload_write),
    .dbus_cmd_payload_wdata   (dbus_cmd_payload_wdata),
    .dbus_cmd_payload_wmask   (dbus_cmd_payload_wmask),
    .dbus_rsp_valid           (dbus_rsp_valid),
    .dbus_rsp_ready           (dbus_rsp_ready),
    .dbus_rsp_payload_rdata   (dbus_rsp_payload_rdata),
    .mem_cmd_valid            (mem_cmd_valid),
    .mem_cmd_ready            (mem_cmd_ready),
    .mem_cmd_payload_address  (mem_cmd_payload_address),
    .mem_cmd_payload_write    (mem_cmd_payload_write),
    .mem_cmd_payload_wdata    (mem_cmd_payload_wdata),
    .mem_cmd_payload_wmask    (mem_cmd_payload_wmask),
    .mem_rsp_valid            (mem_rsp_valid),
    .mem_rsp_ready            (mem_rsp_ready),
    .mem_rsp_payload_rdata    (mem_rsp_payload_rdata),
    .protocol_error           (protocol_error)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int tagq[$];      // outstanding read sources, oldest first (0 ibus, 1 dbus)
  int last_src = 0; // master served by the latest handshake
  int lock = -1;    // master whose grant is held, -1 when free
  bit m_perr = 0;
  bit hs_i = 0;
  bit hs_d = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    tagq.delete();
    last_src = 0;
    lock = -1;
    m_perr = 0;
  endtask

  // One clock cycle: called at a falling edge with inputs already applied.
  task automatic cyc();
    int  cnt;
    bit  ie, de, gv, g, hs, head, exp_mrr, exp_iv, exp_dv, wr;
    #2;
    cnt = tagq.size();
    ie = ibus_cmd_valid && (cnt < DEPTH);
    de = dbus_cmd_valid && (dbus_cmd_payload_write || (cnt < DEPTH));
    if (lock == 0) begin
      g = 0; gv = ibus_cmd_valid;
    end else if (lock == 1) begin
      g = 1; gv = dbus_cmd_valid;
    end else begin
      gv = ie || de;
      if (ie && de) g = (last_src == 0);
      else          g = de;
    end
    hs = gv && mem_cmd_ready;
    wr = g ? dbus_cmd_payload_write : 1'b0;

    chk("mem_cmd_valid", 32'(mem_cmd_valid), 32'(gv));
    chk("ibus_cmd_ready", 32'(ibus_cmd_ready), 32'(gv && !g && mem_cmd_ready));
    chk("dbus_cmd_ready", 32'(dbus_cmd_ready), 32'(gv && g && mem_cmd_ready));
    if (gv) begin
      chk("mem_cmd_address", mem_cmd_payload_address,
          g ? dbus_cmd_payload_address : ibus_cmd_payload_address);
      chk("mem_cmd_write", 32'(mem_cmd_payload_write), 32'(wr));
      chk("mem_cmd_wmask", 32'(mem_cmd_payload_wmask),
          32'(g ? dbus_cmd_payload_wmask : 4'h0));
      if (g) chk("mem_cmd_wdata", mem_cmd_payload_wdata, dbus_cmd_payload_wdata);
    end

    if (cnt > 0) begin
      head    = (tagq[0] == 1);
      exp_iv  = mem_rsp_valid && !head;
      exp_dv  = mem_rsp_valid && head;
      exp_mrr = head ? dbus_rsp_ready : ibus_rsp_ready;
    end else begin
      exp_iv  = 0;
      exp_dv  = 0;
      exp_mrr = mem_rsp_valid;
    end
    chk("ibus_rsp_valid", 32'(ibus_rsp_valid), 32'(exp_iv));
    chk("dbus_rsp_valid", 32'(dbus_rsp_valid), 32'(exp_dv));
    chk("mem_rsp_ready", 32'(mem_rsp_ready), 32'(exp_mrr));
    if (exp_iv) chk("ibus_rdata", ibus_rsp_payload_rdata, mem_rsp_payload_rdata);
    if (exp_dv) chk("dbus_rdata", dbus_rsp_payload_rdata, mem_rsp_payload_rdata);
    chk("protocol_error", 32'(protocol_error), 32'(m_perr));

    @(posedge clk);
    if (cnt > 0 && mem_rsp_valid && exp_mrr) void'(tagq.pop_front());
    if (cnt == 0 && mem_rsp_valid) m_perr = 1;
    if (hs) begin
      last_src = g;
      if (!wr) tagq.push_back(int'(g));
    end
    if (lock < 0 && gv && !mem_cmd_ready) lock = g;
    else if (lock >= 0 && hs)             lock = -1;
    hs_i = hs && !g;
    hs_d = hs && g;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ibus_cmd_valid = 0;
    dbus_cmd_valid = 0;
    dbus_cmd_payload_write = 0;
    mem_cmd_ready = 0;
    mem_rsp_valid = 0;
    ibus_rsp_ready = 0;
    dbus_rsp_ready = 0;
  endtask

  initial begin
    // Reset state
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_mem_cmd_valid", 32'(mem_cmd_valid), 32'd0);
    chk("rst_mem_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    chk("rst_protocol_error", 32'(protocol_error), 32'd0);
    @(negedge clk);
    reset = 1;
    cyc();

    // Tie-break: dbus wins first, then ibus
    ibus_cmd_valid = 1; ibus_cmd_payload_address = 32'h0;
    dbus_cmd_valid = 1; dbus_cmd_payload_address = 32'h100; dbus_cmd_payload_write = 0;
    mem_cmd_ready = 1;
    #1 chk("tie_first_dbus", 32'(dbus_cmd_ready), 32'd1);
    cyc();
    dbus_cmd_valid = 0;
    #1 chk("tie_second_addr", mem_cmd_payload_address, 32'h0);
    cyc();
    ibus_cmd_valid = 0; mem_cmd_ready = 0;
    mem_rsp_valid = 1; mem_rsp_payload_rdata = 32'hAAAA;
    ibus_rsp_ready = 1; dbus_rsp_ready = 1;
    #1 chk("tie_rsp1_dbus", 32'(dbus_rsp_valid), 32'd1);
    cyc();
    mem_rsp_payload_rdata = 32'hBBBB;
    #1 chk("tie_rsp2_ibus", ibus_rsp_payload_rdata & {32{ibus_rsp_valid}}, 32'hBBBB);
    cyc();
    mem_rsp_valid = 0;
    cyc();

    // Hold: ibus locked while memory stalls
    ibus_cmd_valid = 1; ibus_cmd_payload_address = 32'h0; mem_cmd_ready = 0;
    cyc();
    dbus_cmd_valid = 1; dbus_cmd_payload_address = 32'h300;
    for (int k = 0; k < 3; k++) begin
      #1 chk("hold_addr", mem_cmd_payload_address, 32'h0);
      cyc();
    end
    mem_cmd_ready = 1;
    #1 chk("hold_release_ibus", 32'(ibus_cmd_ready), 32'd1);
    cyc();
    ibus_cmd_valid = 0;
    cyc();
    dbus_cmd_valid = 0; mem_cmd_ready = 0;
    mem_rsp_valid = 1;
    cyc();
    cyc();
    mem_rsp_valid = 0;

    // Full: four ibus reads outstanding, fifth stalls, write still passes
    ibus_cmd_valid = 1; mem_cmd_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      ibus_cmd_payload_address = 32'(k * 16);
      cyc();
    end
    ibus_cmd_payload_address = 32'h50;
    dbus_cmd_valid = 1; dbus_cmd_payload_write = 1; dbus_cmd_payload_address = 32'h200;
    dbus_cmd_payload_wdata = 32'hCAFE_F00D; dbus_cmd_payload_wmask = 4'hF;
    #1 chk("full_ibus_stalled", 32'(ibus_cmd_ready), 32'd0);
    chk("full_write_passes", 32'(dbus_cmd_ready), 32'd1);
    cyc();
    dbus_cmd_valid = 0; dbus_cmd_payload_write = 0;
    mem_rsp_valid = 1; ibus_rsp_ready = 1; mem_rsp_payload_rdata = 32'h1234;
    #1 chk("full_pop_cycle_stall", 32'(ibus_cmd_ready), 32'd0);
    cyc();
    mem_rsp_valid = 0;
    #1 chk("full_next_cycle_issue", 32'(ibus_cmd_ready), 32'd1);
    cyc();
    ibus_cmd_valid = 0; mem_cmd_ready = 0;
    mem_rsp_valid = 1;
    for (int k = 0; k < 4; k++) cyc();
    mem_rsp_valid = 0;

    // Backpressure on the head-tag master
    ibus_cmd_valid = 1; ibus_cmd_payload_address = 32'h60; mem_cmd_ready = 1;
    cyc();
    ibus_cmd_valid = 0; mem_cmd_ready = 0;
    mem_rsp_valid = 1; ibus_rsp_ready = 0; dbus_rsp_ready = 1;
    for (int k = 0; k < 2; k++) begin
      #1 chk("bp_mem_rsp_ready", 32'(mem_rsp_ready), 32'd0);
      chk("bp_dbus_rsp_valid", 32'(dbus_rsp_valid), 32'd0);
      cyc();
    end
    ibus_rsp_ready = 1;
    cyc();
    mem_rsp_valid = 0;
    cyc();

    // Spurious response
    mem_rsp_valid = 1;
    #1 chk("spur_ready", 32'(mem_rsp_ready), 32'd1);
    cyc();
    mem_rsp_valid = 0;
    #1 chk("spur_error_set", 32'(protocol_error), 32'd1);
    cyc();
    cyc();

    // Reset with two reads outstanding
    ibus_cmd_valid = 1; mem_cmd_ready = 1;
    ibus_cmd_payload_address = 32'h70;
    cyc();
    ibus_cmd_payload_address = 32'h80;
    cyc();
    idle_inputs();
    reset = 0;
    mem_rsp_valid = 1;
    #1;
    chk("rst_mid_perr", 32'(protocol_error), 32'd0);
    chk("rst_mid_empty", 32'(mem_rsp_ready), 32'd1);
    chk("rst_mid_ibus_rsp", 32'(ibus_rsp_valid), 32'd0);
    mem_rsp_valid = 0;
    #1;
    chk("rst_mid_outputs",
        32'({mem_cmd_valid, ibus_cmd_ready, dbus_cmd_ready, ibus_rsp_valid,
             dbus_rsp_valid, mem_rsp_ready}), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1;
    mem_rsp_valid = 1;
    cyc();
    mem_rsp_valid = 0;
    cyc();

    // Randomized traffic; masters hold a command until it is accepted
    for (int n = 0; n < 3000; n++) begin
      if (!ibus_cmd_valid || hs_i) begin
        ibus_cmd_valid = 1'($urandom_range(0, 1));
        ibus_cmd_payload_address = $urandom;
      end
      if (!dbus_cmd_valid || hs_d) begin
        dbus_cmd_valid = 1'($urandom_range(0, 1));
        dbus_cmd_payload_address = $urandom;
        dbus_cmd_payload_write = 1'($urandom_range(0, 1));
        dbus_cmd_payload_wdata = $urandom;
        dbus_cmd_payload_wmask = 4'($urandom);
      end
      mem_cmd_ready = ($urandom_range(0, 3) != 0);
      ibus_rsp_ready = 1'($urandom_range(0, 1));
      dbus_rsp_ready = 1'($urandom_range(0, 1));
      if (tagq.size() > 0) mem_rsp_valid = 1'($urandom_range(0, 1));
      else                 mem_rsp_valid = ($urandom_range(0, 200) == 0);
      mem_rsp_payload_rdata = $urandom;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
